card_blitter: RTL and testbench

- Writer counterpart to the 1-bit bitmap ROM read path.
- Copies one SPR_W x SPR_H 1-bit sprite (card face, glyph, title fragment) from a sync-read bitmap ROM into the 1-bit framebuffer RAM write port, at a requested (x0, y0).
- Sits between the game controller (issues start) and the framebuffer RAM; the video scan-out keeps reading the framebuffer independently.

---
 rtl/card_blitter_pkg.sv | 33 +++
 rtl/card_blitter_if.sv | 29 ++
 rtl/blit_addr_gen.sv | 49 ++++
 rtl/card_blitter.sv | 112 +++++++++++
 tb/tb_card_blitter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/card_blitter_pkg.sv
// card_blitter shared types and constants.
// Sprite geometry, framebuffer size and the blitter FSM state type.
package card_blitter_pkg;

    localparam int ROM_ADDR_WIDTH = 15;
    localparam int FB_ADDR_WIDTH  = 17;
    localparam int FB_WIDTH       = 320;
    localparam int FB_HEIGHT      = 240;
    localparam int SPR_W          = 32;
    localparam int SPR_H          = 48;
    localparam int COL_W          = $clog2(SPR_W);
    localparam int ROW_W          = $clog2(SPR_H);
    localparam int CRD_W          = 11;

    typedef logic [ROM_ADDR_WIDTH-1:0] rom_addr_t;
    typedef logic [FB_ADDR_WIDTH-1:0]  fb_addr_t;
    typedef logic [CRD_W-1:0]          coord_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } blit_state_t;

    // Linear framebuffer address, modulo 2^FB_ADDR_WIDTH.
    // Only used once per blit, to seed the row base.
    function automatic fb_addr_t fb_lin(input logic [9:0] x,
                                        input logic [9:0] y);
        return fb_addr_t'(y) * fb_addr_t'(FB_WIDTH) + fb_addr_t'(x);
    endfunction

endpackage

// File: rtl/card_blitter_if.sv
// card_blitter bus bundle.
// Controller request/status, ROM read port and framebuffer write port.
interface card_blitter_if;
    import card_blitter_pkg::*;

    logic        start;
    logic [9:0]  x0;
    logic [9:0]  y0;
    rom_addr_t   src_base;
    logic        transparent;
    logic        busy;
    logic        done;
    rom_addr_t   rom_addr;
    logic        rom_dout;
    logic        fb_we;
    fb_addr_t    fb_addr;
    logic        fb_din;

    modport master (
        output start, x0, y0, src_base, transparent, rom_dout,
        input  busy, done, rom_addr, fb_we, fb_addr, fb_din
    );

    modport slave (
        input  start, x0, y0, src_base, transparent, rom_dout,
        output busy, done, rom_addr, fb_we, fb_addr, fb_din
    );

endinterface

// File: rtl/blit_addr_gen.sv
// Sprite walk: col/row counters, ROM address and framebuffer address.
// Row base advances by FB_WIDTH per row, so no per-pixel multiply.
module blit_addr_gen
    import card_blitter_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             advance,
    input  rom_addr_t        src_base,
    input  logic [9:0]       x0,
    input  logic [9:0]       y0,
    output rom_addr_t        rom_addr,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output fb_addr_t         fb_cur,
    output logic             last
);

    fb_addr_t row_base;
    logic     col_end;

    assign col_end = (col == COL_W'(SPR_W - 1));
    assign last    = col_end && (row == ROW_W'(SPR_H - 1));
    assign fb_cur  = row_base + fb_addr_t'(col);

    // Seed on accept, then step one pixel per RUN cycle until the last.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
        end else if (load) begin
            rom_addr <= src_base;
            col      <= '0;
            row      <= '0;
            row_base <= fb_lin(x0, y0);
        end else if (advance && !last) begin
            rom_addr <= rom_addr + rom_addr_t'(1);
            col      <= col + COL_W'(1);
            if (col_end) begin
                row      <= row + ROW_W'(1);
                row_base <= row_base + fb_addr_t'(FB_WIDTH);
            end
        end
    end

endmodule

// File: rtl/card_blitter.sv
// 1-bit sprite blitter: bitmap ROM -> framebuffer RAM write port.
// FSM plus two pipeline stages matching the registered ROM read.
module card_blitter
    import card_blitter_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    card_blitter_if.slave  bus
);

    blit_state_t      state;
    logic [9:0]       x0_q;
    logic [9:0]       y0_q;
    logic             tr_q;
    logic             accept;
    logic             running;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    fb_addr_t         fb_cur;
    logic             last;

    logic             p_valid;
    coord_t           px;
    coord_t           py;
    fb_addr_t         p_fbaddr;
    logic             wr;

    assign accept  = (state == IDLE) && bus.start;
    assign running = (state == RUN);

    blit_addr_gen u_addr_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .advance  (running),
        .src_base (bus.src_base),
        .x0       (bus.x0),
        .y0       (bus.y0),
        .rom_addr (bus.rom_addr),
        .col      (col),
        .row      (row),
        .fb_cur   (fb_cur),
        .last     (last)
    );

    // Control FSM: accept, walk, drain pipeline, pulse done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            x0_q     <= '0;
            y0_q     <= '0;
            tr_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        x0_q     <= bus.x0;
                        y0_q     <= bus.y0;
                        tr_q     <= bus.transparent;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (last) state <= DRAIN;
                end
                DRAIN: begin
                    if (!p_valid) begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Clip against the screen and apply transparency on the ROM bit.
    assign wr = p_valid
              && (px < coord_t'(FB_WIDTH))
              && (py < coord_t'(FB_HEIGHT))
              && (bus.rom_dout || !tr_q);

    // Stage 1 tracks the ROM read; stage 2 issues the framebuffer write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_valid     <= 1'b0;
            px          <= '0;
            py          <= '0;
            p_fbaddr    <= '0;
            bus.fb_we   <= 1'b0;
            bus.fb_addr <= '0;
            bus.fb_din  <= 1'b0;
        end else begin
            p_valid    <= running;
            px         <= coord_t'(x0_q) + coord_t'(col);
            py         <= coord_t'(y0_q) + coord_t'(row);
            p_fbaddr   <= fb_cur;
            bus.fb_we  <= wr;
            bus.fb_din <= bus.rom_dout;
            if (wr) bus.fb_addr <= p_fbaddr;
        end
    end

endmodule

// File: tb/tb_card_blitter.sv
// Directed bench for card_blitter with a write scoreboard.
// Behavioural sync-read ROM, pixel model computed per request.
module tb_card_blitter;

    localparam int N    = 32 * 48;
    localparam int FBW  = 320;
    localparam int FBH  = 240;
    localparam int ROMN = 32768;

    typedef struct {
        int   cyc;
        int   addr;
        logic din;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   wr_count = 0;
    int   rom_mode = 0;
    int   rom_k = -1;
    int   rom_src = 0;
    wr_t  q[$];

    always #5 clk = ~clk;

    card_blitter_if bus();

    card_blitter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic rom_bit(input int a);
        if (rom_mode == 0) return 1'b1;
        return a[0] ^ a[5];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) bus.rom_dout <= rom_bit(int'(bus.rom_addr));

    always @(negedge clk) begin
        if (rom_k >= 0 && cyc >= rom_k && cyc < rom_k + N) begin
            tests++;
            assert (int'(bus.rom_addr) === (rom_src + cyc - rom_k) % ROMN)
            else begin
                fails++;
                $error("FAIL rom_addr cyc=%0d got %0d want %0d", cyc,
                       bus.rom_addr, (rom_src + cyc - rom_k) % ROMN);
            end
        end
        if (bus.fb_we === 1'b1) begin
            wr_count++;
            tests++;
            assert (q.size() > 0)
            else begin
                fails++;
                $error("FAIL unexpected_write cyc=%0d addr=%0d want none",
                       cyc, bus.fb_addr);
            end
            if (q.size() > 0) begin
                wr_t e;
                e = q.pop_front();
                tests++;
                assert (cyc === e.cyc && int'(bus.fb_addr) === e.addr &&
                        bus.fb_din === e.din)
                else begin
                    fails++;
                    $error("FAIL fb_write got cyc=%0d addr=%0d din=%0b want cyc=%0d addr=%0d din=%0b",
                           cyc, bus.fb_addr, bus.fb_din, e.cyc, e.addr, e.din);
                end
            end
            tests++;
            assert (int'(bus.fb_addr) < FBW * FBH)
            else begin
                fails++;
                $error("FAIL fb_range addr=%0d want <%0d", bus.fb_addr, FBW * FBH);
            end
        end
    end

    task automatic start_blit(input int x, input int y, input int src,
                              input bit tr, output int k);
        @(negedge clk);
        bus.x0 = 10'(x);
        bus.y0 = 10'(y);
        bus.src_base = 15'(src);
        bus.transparent = tr;
        bus.start = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < N; i++) begin
            int px, py, a;
            logic d;
            px = x + i % 32;
            py = y + i / 32;
            a = (src + i) % ROMN;
            d = rom_bit(a);
            if (px < FBW && py < FBH && (d || !tr))
                q.push_back('{k + i + 2, py * FBW + px, d});
        end
        wr_count = 0;
        rom_src = src;
        rom_k = k;
        @(negedge clk);
        bus.start = 1'b0;
        tests++;
        assert (bus.busy === 1'b1)
        else begin
            fails++;
            $error("FAIL busy_after_accept got %0b want 1", bus.busy);
        end
    endtask

    task automatic finish_blit(input int k, input int exp_writes,
                               input int mid_at, input bit done_start);
        int got;
        if (mid_at > 0) begin
            repeat (mid_at) @(negedge clk);
            bus.x0 = bus.x0 + 10'd17;
            bus.y0 = bus.y0 + 10'd3;
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        got = -1;
        for (int t = 0; t < N + 20 && got < 0; t++) begin
            @(negedge clk);
            if (bus.done === 1'b1) got = cyc;
        end
        tests++;
        assert (got === k + N + 2)
        else begin
            fails++;
            $error("FAIL done_cycle got %0d want %0d", got, k + N + 2);
        end
        tests++;
        assert (bus.busy === 1'b1)
        else begin
            fails++;
            $error("FAIL busy_in_done got %0b want 1", bus.busy);
        end
        if (done_start) begin
            bus.x0 = 10'd5;
            bus.start = 1'b1;
        end
        @(negedge clk);
        bus.start = 1'b0;
        tests++;
        assert (bus.busy === 1'b0 && bus.done === 1'b0)
        else begin
            fails++;
            $error("FAIL idle_after_done got busy=%0b done=%0b want 0 0",
                   bus.busy, bus.done);
        end
        if (done_start) begin
            repeat (5) @(negedge clk);
            tests++;
            assert (bus.busy === 1'b0)
            else begin
                fails++;
                $error("FAIL start_in_done got busy=%0b want 0", bus.busy);
            end
        end
        #1;
        tests++;
        assert (q.size() == 0)
        else begin
            fails++;
            $error("FAIL missing_writes got %0d left want 0", q.size());
        end
        tests++;
        assert (wr_count === exp_writes)
        else begin
            fails++;
            $error("FAIL write_count got %0d want %0d", wr_count, exp_writes);
        end
        rom_k = -1;
    endtask

    initial begin
        int k;
        bus.start = 1'b0;
        bus.x0 = '0;
        bus.y0 = '0;
        bus.src_base = '0;
        bus.transparent = 1'b0;
        #12;
        tests++;
        assert (bus.busy === 1'b0 && bus.done === 1'b0 && bus.fb_we === 1'b0 &&
                bus.fb_addr === 17'd0 && bus.fb_din === 1'b0 &&
                bus.rom_addr === 15'd0)
        else begin
            fails++;
            $error("FAIL reset_state got busy=%0b done=%0b we=%0b addr=%0d din=%0b rom=%0d want all 0",
                   bus.busy, bus.done, bus.fb_we, bus.fb_addr, bus.fb_din,
                   bus.rom_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        rom_mode = 0;
        start_blit(0, 0, 0, 1'b0, k);
        finish_blit(k, 1536, 0, 1'b0);

        rom_mode = 1;
        start_blit(100, 50, 0, 1'b1, k);
        finish_blit(k, 768, 0, 1'b0);

        start_blit(100, 50, 0, 1'b0, k);
        finish_blit(k, 1536, 0, 1'b0);

        rom_mode = 0;
        start_blit(300, 220, 0, 1'b0, k);
        finish_blit(k, 400, 0, 1'b0);

        start_blit(40, 60, 0, 1'b0, k);
        finish_blit(k, 1536, 500, 1'b1);

        rom_mode = 1;
        start_blit(10, 10, ROMN - 10, 1'b1, k);
        finish_blit(k, 768, 0, 1'b0);

        rom_mode = 0;
        start_blit(0, 0, 0, 1'b0, k);
        while (cyc < k + 700) @(posedge clk);
        @(posedge clk);
        #2;
        rom_k = -1;
        q.delete();
        reset_n = 1'b0;
        #1;
        tests++;
        assert (bus.fb_we === 1'b0 && bus.busy === 1'b0 && bus.done === 1'b0)
        else begin
            fails++;
            $error("FAIL async_reset got we=%0b busy=%0b done=%0b want 0 0 0",
                   bus.fb_we, bus.busy, bus.done);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        start_blit(0, 0, 0, 1'b0, k);
        finish_blit(k, 1536, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
